// File: rtl/ps_stage_pipe_pkg.sv
// -----------------------------------------------------------------------------
// ps_stage_pipe_pkg
//   Shared definitions for the clocked Program Storage (PS) stage:
//   - default widths and depths for the stage parameters
//   - opcode encodings the stage reacts to (ABSORB)
//   - small elaboration/runtime helpers for pointer wrap and address width
// -----------------------------------------------------------------------------
package ps_stage_pipe_pkg;

  // Default field widths and depths.
  localparam int CG_W_DEF       = 4;   // colour/generation field
  localparam int DEST_W_DEF     = 8;   // PS address field
  localparam int PS_DEPTH_DEF   = 256; // PS entries
  localparam int PS_W_DEF       = 24;  // instruction word
  localparam int OPC_W_DEF      = 6;   // opcode, top bits of the instruction
  localparam int CZDD_W_DEF     = 32;  // data field, passed through
  localparam int FIFO_DEPTH_DEF = 4;   // output buffer entries
  localparam int CNT_W_DEF      = 16;  // ABSORB drop counter

  // Opcodes the stage itself interprets. Everything else is opaque payload.
  // OPC_NOP is what an out-of-range DEST produces (INSTR forced to zero), so
  // ABSORB must never be encoded as zero.
  typedef enum logic [5:0] {
    OPC_NOP    = 6'h00,
    OPC_ABSORB = 6'h3E
  } opc_e;

  // Next value of a circular pointer over [0, depth-1]; depth need not be a
  // power of two.
  function automatic int wrap_inc(input int ptr, input int depth);
    return (ptr + 1 >= depth) ? 0 : ptr + 1;
  endfunction

  // Bits needed to index 'depth' entries, never less than one.
  function automatic int addr_bits(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/ps_fifo.sv
// -----------------------------------------------------------------------------
// ps_fifo
//   Synchronous show-ahead FIFO used as the output elastic buffer of the PS
//   stage. The oldest entry is always visible on dout; pop retires it.
//   Simultaneous push and pop leaves count unchanged, also when full.
//   Pointers wrap modulo DEPTH (DEPTH need not be a power of two).
//
// Ports
//   CLK    in   1         clock, rising edge
//   MR_n   in   1         asynchronous active-low reset (pointers, count)
//   push   in   1         write din at the tail
//   pop    in   1         retire the head entry
//   din    in   W         write data
//   dout   out  W         head entry (undefined content while count == 0)
//   count  out  CW        number of stored entries, 0..DEPTH
// -----------------------------------------------------------------------------
module ps_fifo
  import ps_stage_pipe_pkg::*;
#(
  parameter  int W     = 8,
  parameter  int DEPTH = FIFO_DEPTH_DEF,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = addr_bits(DEPTH)
) (
  input  logic          CLK,
  input  logic          MR_n,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // A pop on an empty buffer is ignored; a push on a full buffer is only
  // legal when the same edge also pops.
  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((int'(count) < DEPTH) || do_pop);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; this is what makes same-edge read-old-word work.
  always_ff @(posedge CLK or negedge MR_n) begin
    if (!MR_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= PW'(wrap_inc(int'(wr_ptr), DEPTH));
      if (do_pop)  rd_ptr <= PW'(wrap_inc(int'(rd_ptr), DEPTH));
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage arrays are not reset; validity is carried by count and the
  // pointers, so clearing the data would only cost reset fan-out.
  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign dout = mem[rd_ptr];

endmodule

// File: rtl/ps_stage_pipe.sv
// -----------------------------------------------------------------------------
// ps_stage_pipe
//   Clocked Program Storage stage of the data-driven pipeline.
//   Token in  : {CG, DEST, CZDD}
//   Token out : {CG, INSTR, CZDD} with INSTR = PS[DEST] (0 when DEST is out of
//               range). Two edges of latency, one token per cycle.
//
//   Datapath: accept -> S1 (synchronous PS read) -> output FIFO (show-ahead).
//   Flow control is credit based: Ack_out is computed from registered state
//   only, so there is no combinational path from Ack_in to Ack_out. A token
//   sitting in S1 always owns a free FIFO slot.
//
//   ABSORB tokens are either forwarded with DEL=0 or, with DROP_ABSORB=1,
//   discarded at the S1->FIFO hand-off and counted in a saturating counter.
//
// Ports
//   CLK         in   1                     clock, rising edge
//   MR_n        in   1                     async active-low master reset
//   Send_in     in   1                     input token valid
//   Ack_out     out  1                     stage can accept a token
//   PACKET_IN   in   CG_W+DEST_W+CZDD_W    {CG, DEST, CZDD}
//   Send_out    out  1                     output token valid
//   Ack_in      in   1                     downstream accepts
//   PACKET_OUT  out  CG_W+PS_W+CZDD_W      {CG, INSTR, CZDD}, 0 when idle
//   DEL         out  1                     0 when head opcode is ABSORB
//   PL_WE       in   1                     program-load write enable
//   PL_ADDR     in   DEST_W                program-load address
//   PL_DATA     in   PS_W                  program-load data
//   ABS_CNT     out  CNT_W                 dropped ABSORB tokens, saturating
// -----------------------------------------------------------------------------
module ps_stage_pipe
  import ps_stage_pipe_pkg::*;
#(
  parameter int CG_W        = CG_W_DEF,
  parameter int DEST_W      = DEST_W_DEF,
  parameter int PS_DEPTH    = PS_DEPTH_DEF,
  parameter int PS_W        = PS_W_DEF,
  parameter int OPC_W       = OPC_W_DEF,
  parameter int CZDD_W      = CZDD_W_DEF,
  parameter int FIFO_DEPTH  = FIFO_DEPTH_DEF,
  parameter bit DROP_ABSORB = 1'b0,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic                          CLK,
  input  logic                          MR_n,
  input  logic                          Send_in,
  output logic                          Ack_out,
  input  logic [CG_W+DEST_W+CZDD_W-1:0] PACKET_IN,
  output logic                          Send_out,
  input  logic                          Ack_in,
  output logic [CG_W+PS_W+CZDD_W-1:0]   PACKET_OUT,
  output logic                          DEL,
  input  logic                          PL_WE,
  input  logic [DEST_W-1:0]             PL_ADDR,
  input  logic [PS_W-1:0]               PL_DATA,
  output logic [CNT_W-1:0]              ABS_CNT
);

  localparam int OUT_W = CG_W + PS_W + CZDD_W;
  localparam int PS_AW = addr_bits(PS_DEPTH);    // <= DEST_W since PS_DEPTH <= 2**DEST_W
  localparam int FCW   = $clog2(FIFO_DEPTH + 1);
  localparam logic [OPC_W-1:0] ABSORB = OPC_W'(OPC_ABSORB);

  // ---------------------------------------------------------------------------
  // Input token fields
  // ---------------------------------------------------------------------------
  logic [CG_W-1:0]   in_cg;
  logic [DEST_W-1:0] in_dest;
  logic [CZDD_W-1:0] in_czdd;

  assign {in_cg, in_dest, in_czdd} = PACKET_IN;

  // ---------------------------------------------------------------------------
  // Internal state
  // ---------------------------------------------------------------------------
  logic [PS_W-1:0]   ps_mem [PS_DEPTH];
  logic              s1_valid;
  logic [CG_W-1:0]   s1_cg;
  logic [PS_W-1:0]   s1_instr;
  logic [CZDD_W-1:0] s1_czdd;
  logic [CNT_W-1:0]  abs_cnt;

  logic [FCW-1:0]    fifo_count;
  logic [OUT_W-1:0]  fifo_head;
  logic              fifo_push;
  logic              fifo_pop;

  logic              accept;
  logic              s1_drop;
  logic              head_absorb;

  // ---------------------------------------------------------------------------
  // Credit-based input acceptance. Both terms are registers, so Ack_out never
  // depends combinationally on Ack_in. The MR_n term forces Ack_out low for
  // the whole reset window, not just after the next edge.
  // ---------------------------------------------------------------------------
  assign Ack_out = MR_n && ((int'(fifo_count) + int'(s1_valid)) < FIFO_DEPTH);
  assign accept  = Send_in && Ack_out;

  // ---------------------------------------------------------------------------
  // Program storage write port. Writes beyond PS_DEPTH are dropped so a
  // non-power-of-two PS never aliases onto low addresses. The array keeps its
  // contents across MR_n.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (PL_WE && (int'(PL_ADDR) < PS_DEPTH)) begin
      ps_mem[PL_ADDR[PS_AW-1:0]] <= PL_DATA;
    end
  end

  // ---------------------------------------------------------------------------
  // S1: synchronous PS read plus the CG/CZDD side fields. Loaded only on an
  // accept edge, so an idle (possibly undriven) PACKET_IN never reaches the
  // datapath. A same-edge PL write to the same address is not yet visible
  // here: the read returns the word stored before the edge.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (accept) begin
      s1_cg    <= in_cg;
      s1_czdd  <= in_czdd;
      s1_instr <= (int'(in_dest) < PS_DEPTH) ? ps_mem[in_dest[PS_AW-1:0]] : '0;
    end
  end

  // S1 always drains on the following edge: the credit check guaranteed it a
  // FIFO slot (or it is being dropped).
  always_ff @(posedge CLK or negedge MR_n) begin
    if (!MR_n) begin
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= accept;
    end
  end

  // ---------------------------------------------------------------------------
  // S1 -> FIFO hand-off and ABSORB dropping
  // ---------------------------------------------------------------------------
  assign s1_drop   = DROP_ABSORB && s1_valid && (s1_instr[PS_W-1 -: OPC_W] == ABSORB);
  assign fifo_push = s1_valid && !s1_drop;
  assign fifo_pop  = Send_out && Ack_in;

  // Saturating drop counter: holds at all-ones instead of wrapping.
  always_ff @(posedge CLK or negedge MR_n) begin
    if (!MR_n) begin
      abs_cnt <= '0;
    end else if (s1_drop && (abs_cnt != '1)) begin
      abs_cnt <= abs_cnt + CNT_W'(1);
    end
  end

  assign ABS_CNT = abs_cnt;

  // ---------------------------------------------------------------------------
  // Output elastic buffer
  // ---------------------------------------------------------------------------
  ps_fifo #(
    .W     (OUT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_out_fifo (
    .CLK   (CLK),
    .MR_n  (MR_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   ({s1_cg, s1_instr, s1_czdd}),
    .dout  (fifo_head),
    .count (fifo_count)
  );

  // ---------------------------------------------------------------------------
  // Output drive. The head entry only changes on a pop, so PACKET_OUT and DEL
  // hold steady while Send_out is stalled by Ack_in. An empty buffer presents
  // a clean all-zero packet with DEL=1.
  // ---------------------------------------------------------------------------
  assign Send_out    = (fifo_count != '0);
  assign head_absorb = (fifo_head[CZDD_W+PS_W-1 -: OPC_W] == ABSORB);

  // NOTE: defaults come first in always_comb so every path assigns every
  // output and no latch can be inferred.
  always_comb begin
    PACKET_OUT = '0;
    DEL        = 1'b1;
    if (Send_out) begin
      PACKET_OUT = fifo_head;
      DEL        = !head_absorb;
    end
  end

endmodule

// File: tb/tb_ps_stage_pipe.sv
// -----------------------------------------------------------------------------
// tb_ps_stage_pipe
//   Self-checking bench for ps_stage_pipe.
//   dut_a : DROP_ABSORB=0, PS_DEPTH=200 (main datapath, scoreboarded)
//   dut_b : DROP_ABSORB=1, CNT_W=2      (ABSORB dropping and counter saturation)
//   Inputs change 1 ns after the rising edge; outputs are sampled on the
//   falling edge.
// -----------------------------------------------------------------------------
module tb_ps_stage_pipe;
  import ps_stage_pipe_pkg::*;

  localparam int CG_W       = 4;
  localparam int DEST_W     = 8;
  localparam int PS_W       = 24;
  localparam int OPC_W      = 6;
  localparam int CZDD_W     = 32;
  localparam int FIFO_DEPTH = 4;
  localparam int A_DEPTH    = 200;
  localparam int IN_W       = CG_W + DEST_W + CZDD_W;
  localparam int OUT_W      = CG_W + PS_W + CZDD_W;
  localparam logic [OPC_W-1:0] ABS_OPC = 6'h3E;

  logic clk;
  logic rst_n;

  // dut_a signals
  logic              a_send_in, a_ack_out, a_send_out, a_ack_in, a_del, a_pl_we;
  logic [IN_W-1:0]   a_packet_in;
  logic [OUT_W-1:0]  a_packet_out;
  logic [DEST_W-1:0] a_pl_addr;
  logic [PS_W-1:0]   a_pl_data;
  logic [15:0]       a_abs_cnt;

  // dut_b signals
  logic              b_send_in, b_ack_out, b_send_out, b_ack_in, b_del, b_pl_we;
  logic [IN_W-1:0]   b_packet_in;
  logic [OUT_W-1:0]  b_packet_out;
  logic [DEST_W-1:0] b_pl_addr;
  logic [PS_W-1:0]   b_pl_data;
  logic [1:0]        b_abs_cnt;

  ps_stage_pipe #(
    .PS_DEPTH    (A_DEPTH),
    .DROP_ABSORB (1'b0)
  ) dut_a (
    .CLK (clk), .MR_n (rst_n),
    .Send_in (a_send_in), .Ack_out (a_ack_out), .PACKET_IN (a_packet_in),
    .Send_out (a_send_out), .Ack_in (a_ack_in), .PACKET_OUT (a_packet_out),
    .DEL (a_del), .PL_WE (a_pl_we), .PL_ADDR (a_pl_addr), .PL_DATA (a_pl_data),
    .ABS_CNT (a_abs_cnt)
  );

  ps_stage_pipe #(
    .DROP_ABSORB (1'b1),
    .CNT_W       (2)
  ) dut_b (
    .CLK (clk), .MR_n (rst_n),
    .Send_in (b_send_in), .Ack_out (b_ack_out), .PACKET_IN (b_packet_in),
    .Send_out (b_send_out), .Ack_in (b_ack_in), .PACKET_OUT (b_packet_out),
    .DEL (b_del), .PL_WE (b_pl_we), .PL_ADDR (b_pl_addr), .PL_DATA (b_pl_data),
    .ABS_CNT (b_abs_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference PS model and scoreboard for dut_a ({DEL, PACKET_OUT} per entry)
  // ---------------------------------------------------------------------------
  logic [PS_W-1:0] model_a [256];
  logic [OUT_W:0]  sb_q [$];
  int              pop_cyc [$];

  function automatic logic [PS_W-1:0] a_lookup(input logic [DEST_W-1:0] dest);
    return (int'(dest) < A_DEPTH) ? model_a[dest] : '0;
  endfunction

  always @(negedge clk) begin
    if (rst_n && a_send_out && a_ack_in) begin
      check("out_expected", 64'(a_send_out), 64'(sb_q.size() != 0));
      if (sb_q.size() != 0) begin
        logic [OUT_W:0] e;
        e = sb_q.pop_front();
        check("out_packet", 64'(a_packet_out), 64'(e[OUT_W-1:0]));
        check("out_del", 64'(a_del), 64'(e[OUT_W]));
        pop_cyc.push_back(cyc);
      end
    end
  end

  // dut_b output observer
  logic             b_seen = 1'b0;
  logic [OUT_W-1:0] b_last = '0;

  always @(negedge clk) begin
    if (b_send_out) begin
      b_seen = 1'b1;
      b_last = b_packet_out;
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks: all start and end 1 ns after a rising edge
  // ---------------------------------------------------------------------------
  task automatic a_load(input int addr, input logic [PS_W-1:0] data);
    a_pl_we   = 1'b1;
    a_pl_addr = DEST_W'(addr);
    a_pl_data = data;
    @(posedge clk); #1;
    if (addr < A_DEPTH) model_a[addr] = data;
    a_pl_we = 1'b0;
  endtask

  task automatic a_send(input logic [CG_W-1:0] cg, input logic [DEST_W-1:0] dest,
                        input logic [CZDD_W-1:0] czdd);
    int budget;
    logic [PS_W-1:0] instr;
    budget      = 200;
    a_send_in   = 1'b1;
    a_packet_in = {cg, dest, czdd};
    do begin
      @(negedge clk);
      budget--;
    end while (!a_ack_out && budget > 0);
    check("send_ack", 64'(a_ack_out), 64'(1));
    @(posedge clk);
    if (budget > 0 || a_ack_out) begin
      instr = a_lookup(dest);
      sb_q.push_back({(instr[PS_W-1 -: OPC_W] != ABS_OPC), cg, instr, czdd});
    end
    #1;
    a_send_in   = 1'b0;
    a_packet_in = 'x;
  endtask

  task automatic a_drain(input string tag);
    int budget;
    budget = 100;
    while (sb_q.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check(tag, 64'(sb_q.size()), 64'(0));
    @(posedge clk); #1;
  endtask

  // Stream n back-to-back tokens through PS[10..19] and verify they leave on
  // n consecutive cycles.
  task automatic a_stream(input int n, input int seed, input string tag);
    int base;
    base = pop_cyc.size();
    for (int i = 0; i < n; i++) begin
      a_send(CG_W'(i + seed), DEST_W'(10 + (i % 10)), 32'hA000_0000 + 32'(seed * 100 + i));
    end
    a_drain({tag, "_drain"});
    check({tag, "_count"}, 64'(pop_cyc.size() - base), 64'(n));
    if (pop_cyc.size() >= base + n) begin
      check({tag, "_span"}, 64'(pop_cyc[base+n-1] - pop_cyc[base]), 64'(n - 1));
    end
  endtask

  task automatic b_load(input int addr, input logic [PS_W-1:0] data);
    b_pl_we   = 1'b1;
    b_pl_addr = DEST_W'(addr);
    b_pl_data = data;
    @(posedge clk); #1;
    b_pl_we = 1'b0;
  endtask

  task automatic b_send(input logic [DEST_W-1:0] dest);
    b_send_in   = 1'b1;
    b_packet_in = {4'd2, dest, 32'hD000};
    @(negedge clk);
    check("b_ack", 64'(b_ack_out), 64'(1));
    @(posedge clk); #1;
    b_send_in   = 1'b0;
    b_packet_in = 'x;
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    int acc;
    logic got;

    a_send_in = 1'b0; a_packet_in = 'x; a_ack_in = 1'b0;
    a_pl_we = 1'b0; a_pl_addr = '0; a_pl_data = '0;
    b_send_in = 1'b0; b_packet_in = 'x; b_ack_in = 1'b1;
    b_pl_we = 1'b0; b_pl_addr = '0; b_pl_data = '0;
    for (int i = 0; i < 256; i++) model_a[i] = '0;

    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check("rst_send_out", 64'(a_send_out), 64'(0));
    check("rst_packet_out", 64'(a_packet_out), 64'(0));
    check("rst_del", 64'(a_del), 64'(1));
    check("rst_ack_out", 64'(a_ack_out), 64'(0));
    check("rst_abs_cnt", 64'(a_abs_cnt), 64'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_ack_out", 64'(a_ack_out), 64'(1));

    // 1. Single token, latency of two edges
    a_load(5, 24'h0A0001);
    a_ack_in = 1'b1;
    a_send(4'd3, 8'd5, 32'h1234);
    check("t1_not_after_e0", 64'(a_send_out), 64'(0));
    @(posedge clk); #1;
    check("t1_valid_after_e1", 64'(a_send_out), 64'(1));
    check("t1_packet", 64'(a_packet_out), 64'({4'd3, 24'h0A0001, 32'h1234}));
    check("t1_del", 64'(a_del), 64'(1));
    a_drain("t1_drain");

    // 2. Ten back-to-back tokens
    for (int i = 0; i < 10; i++) a_load(10 + i, 24'h040000 + 24'(i * 24'h000101));
    a_stream(10, 0, "t2");

    // 3. Backpressure: exactly FIFO_DEPTH tokens accepted, head stable
    a_ack_in  = 1'b0;
    acc       = 0;
    a_send_in = 1'b1;
    for (int c = 0; c < 8; c++) begin
      a_packet_in = {4'(c), 8'(10 + c), 32'hB000 + 32'(c)};
      @(negedge clk);
      got = a_ack_out;
      if (c == 5) check("t3_head_mid", 64'(a_packet_out), 64'(sb_q[0][OUT_W-1:0]));
      @(posedge clk);
      if (got) begin
        acc++;
        sb_q.push_back({1'b1, 4'(c), a_lookup(8'(10 + c)), 32'hB000 + 32'(c)});
      end
      #1;
    end
    a_send_in   = 1'b0;
    a_packet_in = 'x;
    check("t3_accepted", 64'(acc), 64'(FIFO_DEPTH));
    check("t3_ack_low", 64'(a_ack_out), 64'(0));
    check("t3_send_out", 64'(a_send_out), 64'(1));
    check("t3_head_end", 64'(a_packet_out), 64'(sb_q[0][OUT_W-1:0]));
    begin
      int base;
      base     = pop_cyc.size();
      a_ack_in = 1'b1;
      a_drain("t3_drain");
      check("t3_drained", 64'(pop_cyc.size() - base), 64'(FIFO_DEPTH));
    end
    a_stream(5, 3, "t3_resume");

    // 4a. ABSORB forwarded with DEL=0 when not dropping
    a_load(7, {ABS_OPC, 18'h00007});
    a_send(4'd1, 8'd7, 32'hC0DE);
    a_drain("t4_drain");

    // 4b. ABSORB dropped and counted, counter saturates at 3 (CNT_W=2)
    b_load(7, {ABS_OPC, 18'h00007});
    b_load(8, 24'h0C0008);
    b_send(8'd7); b_send(8'd7);
    repeat (3) @(posedge clk); #1;
    check("t4_cnt2", 64'(b_abs_cnt), 64'(2));
    b_send(8'd7);
    repeat (3) @(posedge clk); #1;
    check("t4_cnt3", 64'(b_abs_cnt), 64'(3));
    b_send(8'd7); b_send(8'd7);
    repeat (3) @(posedge clk); #1;
    check("t4_cnt_sat", 64'(b_abs_cnt), 64'(3));
    check("t4_none_emitted", 64'(b_seen), 64'(0));
    b_send(8'd8);
    repeat (3) @(posedge clk); #1;
    check("t4_normal_emitted", 64'(b_seen), 64'(1));
    check("t4_normal_packet", 64'(b_last), 64'({4'd2, 24'h0C0008, 32'hD000}));

    // 5. Same-edge write/read returns the old word; out-of-range DEST
    a_load(9, 24'h090009);
    a_pl_we   = 1'b1;
    a_pl_addr = 8'd9;
    a_pl_data = 24'hFFFFFF;
    a_send(4'd4, 8'd9, 32'hE1);     // expectation uses the old model word
    model_a[9] = 24'hFFFFFF;
    a_pl_we    = 1'b0;
    a_send(4'd5, 8'd9, 32'hE2);
    a_load(250, 24'h123456);        // beyond PS_DEPTH: ignored
    a_send(4'd6, 8'd250, 32'hE3);
    a_load(199, 24'h0D00C7);
    a_send(4'd7, 8'd199, 32'hE4);
    a_drain("t5_drain");

    // 6. Asynchronous reset with tokens queued
    a_ack_in = 1'b0;
    a_send(4'd8, 8'd11, 32'hF1);
    a_send(4'd9, 8'd12, 32'hF2);
    a_send(4'd10, 8'd13, 32'hF3);
    @(posedge clk); #1;
    check("t6_queued", 64'(a_send_out), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    check("t6_send_out", 64'(a_send_out), 64'(0));
    check("t6_packet_out", 64'(a_packet_out), 64'(0));
    check("t6_ack_out", 64'(a_ack_out), 64'(0));
    check("t6_del", 64'(a_del), 64'(1));
    check("t6_b_cnt_clr", 64'(b_abs_cnt), 64'(0));
    sb_q.delete();
    a_ack_in = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t6_no_spurious", 64'(a_send_out), 64'(0));
    end
    @(posedge clk); #1;
    a_send(4'd11, 8'd5, 32'hF5);    // PS[5] survives reset
    a_drain("t6_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

endmodule
